lime_io_bridge: RTL and testbench

Buffered I/O bridge between external devices and the 16-bit multi-cycle processor's `main_input`/`main_output` pins. An input FIFO accepts words from an external producer through a valid/ready handshake and presents the head word to the processor's input pin. An output FIFO captures words the processor writes to its output pin and drains them to an external consumer through a valid/ready handshake. Both FIFOs share the processor's clock domain.

---
 rtl/lime_io_bridge.sv | 149 ++++++++++++++
 tb/tb_lime_io_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lime_io_bridge.sv
// Buffered I/O bridge: input FIFO feeding the processor's main_input, output FIFO draining main_output.
// Optional `LIME_IO_CHANGE_DETECT_EN` turns any change of proc_output into a write event.

module lime_io_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is gated by empty. A push while full
    // (only legal with a pop) overwrites the slot being popped.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) mem_q[wptr_q] <= data_i;
    end

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];
endmodule

module lime_io_bridge #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       ext_in_data,
    input  logic                   ext_in_valid,
    output logic                   ext_in_ready,
    output logic [WIDTH-1:0]       proc_input,
    output logic                   proc_in_valid,
    input  logic                   proc_in_rd,
    input  logic [WIDTH-1:0]       proc_output,
    input  logic                   proc_out_wr,
    output logic [WIDTH-1:0]       ext_out_data,
    output logic                   ext_out_valid,
    input  logic                   ext_out_ready,
    output logic                   out_overflow,
    output logic [$clog2(DEPTH):0] in_count,
    output logic [$clog2(DEPTH):0] out_count
);
    logic in_full, in_empty, in_push, in_pop;
    logic out_full, out_empty, out_push, out_pop, out_wr_evt;
    logic ovf_q, ovf_d;

    // Input side: a full FIFO refuses even with a same-cycle pop, so ready
    // depends on fullness alone.
    assign in_push = ext_in_valid && !in_full;
    assign in_pop  = proc_in_rd && !in_empty;

    lime_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .push_i  (in_push),
        .pop_i   (in_pop),
        .data_i  (ext_in_data),
        .head_o  (proc_input),
        .count_o (in_count),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    assign ext_in_ready  = !in_full;
    assign proc_in_valid = !in_empty;

`ifdef LIME_IO_CHANGE_DETECT_EN
    logic [WIDTH-1:0] shadow_q;

    always_ff @(posedge CLK) begin
        if (Reset) shadow_q <= '0;
        else       shadow_q <= proc_output;
    end

    assign out_wr_evt = proc_out_wr || (proc_output != shadow_q);
`else
    assign out_wr_evt = proc_out_wr;
`endif

    // Output side: a write into a full FIFO survives only if the consumer
    // frees a slot on the same edge.
    assign out_pop  = ext_out_ready && !out_empty;
    assign out_push = out_wr_evt && (!out_full || out_pop);

    lime_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .push_i  (out_push),
        .pop_i   (out_pop),
        .data_i  (proc_output),
        .head_o  (ext_out_data),
        .count_o (out_count),
        .full_o  (out_full),
        .empty_o (out_empty)
    );

    assign ext_out_valid = !out_empty;

    assign ovf_d = ovf_q || (out_wr_evt && !out_push);

    always_ff @(posedge CLK) begin
        if (Reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign out_overflow = ovf_q;
endmodule

// File: tb/tb_lime_io_bridge.sv
// Self-checking bench for lime_io_bridge: directed test-plan cases plus random traffic
// against a queue-based reference model.

module tb_lime_io_bridge;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_valid;
    logic             ext_in_ready;
    logic [WIDTH-1:0] proc_input;
    logic             proc_in_valid;
    logic             proc_in_rd;
    logic [WIDTH-1:0] proc_output;
    logic             proc_out_wr;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready;
    logic             out_overflow;
    logic [CW-1:0]    in_count;
    logic [CW-1:0]    out_count;

    lime_io_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .proc_input    (proc_input),
        .proc_in_valid (proc_in_valid),
        .proc_in_rd    (proc_in_rd),
        .proc_output   (proc_output),
        .proc_out_wr   (proc_out_wr),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .out_overflow  (out_overflow),
        .in_count      (in_count),
        .out_count     (out_count)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain queues of words plus a sticky flag.
    logic [WIDTH-1:0] m_in[$];
    logic [WIDTH-1:0] m_out[$];
    bit               m_ovf;
    logic [WIDTH-1:0] m_shadow;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("in_count",      32'(in_count),      32'(m_in.size()));
        chk("out_count",     32'(out_count),     32'(m_out.size()));
        chk("ext_in_ready",  32'(ext_in_ready),  32'(m_in.size() < DEPTH));
        chk("proc_in_valid", 32'(proc_in_valid), 32'(m_in.size() > 0));
        chk("proc_input",    32'(proc_input),    m_in.size() > 0 ? 32'(m_in[0]) : 32'd0);
        chk("ext_out_valid", 32'(ext_out_valid), 32'(m_out.size() > 0));
        chk("ext_out_data",  32'(ext_out_data),  m_out.size() > 0 ? 32'(m_out[0]) : 32'd0);
        chk("out_overflow",  32'(out_overflow),  32'(m_ovf));
    endtask

    // Apply one clock edge to the model from the currently driven inputs,
    // then let the DUT take the same edge and compare.
    task automatic tick();
        bit wr_evt, opop;
        if (Reset) begin
            m_in.delete();
            m_out.delete();
            m_ovf    = 1'b0;
            m_shadow = '0;
        end else begin
            if (proc_in_rd && m_in.size() > 0) void'(m_in.pop_front());
            if (ext_in_valid && (m_in.size() + ((proc_in_rd && m_in.size() > 0) ? 1 : 0)) < DEPTH)
                m_in.push_back(ext_in_data);
`ifdef LIME_IO_CHANGE_DETECT_EN
            wr_evt = proc_out_wr || (proc_output != m_shadow);
`else
            wr_evt = proc_out_wr;
`endif
            opop = ext_out_ready && m_out.size() > 0;
            if (opop) void'(m_out.pop_front());
            if (wr_evt) begin
                if (m_out.size() < DEPTH) m_out.push_back(proc_output);
                else                      m_ovf = 1'b1;
            end
            m_shadow = proc_output;
        end
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic idle();
        Reset         = 1'b0;
        ext_in_valid  = 1'b0;
        proc_in_rd    = 1'b0;
        proc_out_wr   = 1'b0;
        ext_out_ready = 1'b0;
    endtask

    logic [WIDTH-1:0] last;

    initial begin
        Reset        = 1'b1;
        ext_in_data  = '0;
        ext_in_valid = 1'b0;
        proc_in_rd   = 1'b0;
        proc_output  = '0;
        proc_out_wr  = 1'b0;
        ext_out_ready = 1'b0;
        m_ovf        = 1'b0;
        m_shadow     = '0;
        #1;
        tick(); tick();
        chk("rst_ready", 32'(ext_in_ready), 32'd1);
        chk("rst_ovf",   32'(out_overflow), 32'd0);
        idle();

        // Two pushes, then one pop.
        ext_in_valid = 1'b1; ext_in_data = 16'h1111; tick();
        ext_in_data = 16'h2222; tick();
        ext_in_valid = 1'b0;
        chk("two_push_cnt",  32'(in_count),   32'd2);
        chk("two_push_head", 32'(proc_input), 32'h1111);
        proc_in_rd = 1'b1; tick(); proc_in_rd = 1'b0;
        chk("pop_head", 32'(proc_input), 32'h2222);
        chk("pop_cnt",  32'(in_count),   32'd1);

        // Fill to full; pop with push attempt in the same cycle is refused.
        ext_in_valid = 1'b1;
        ext_in_data = 16'h3333; tick();
        ext_in_data = 16'h4444; tick();
        ext_in_data = 16'h5555; tick();
        chk("full_ready", 32'(ext_in_ready), 32'd0);
        ext_in_data = 16'h6666; proc_in_rd = 1'b1; tick();
        ext_in_valid = 1'b0;
        chk("full_pop_cnt",   32'(in_count),     32'd3);
        chk("full_pop_ready", 32'(ext_in_ready), 32'd1);
        last = '0;
        for (int i = 0; i < 3; i++) begin
            last = proc_input;
            tick();
        end
        proc_in_rd = 1'b0;
        chk("wrap_last", 32'(last), 32'h5555);
        chk("drained",   32'(proc_in_valid), 32'd0);

        // Output write then drain.
        proc_output = 16'hBEEF; proc_out_wr = 1'b1; tick();
        proc_out_wr = 1'b0;
        chk("beef_data",  32'(ext_out_data),  32'hBEEF);
        chk("beef_valid", 32'(ext_out_valid), 32'd1);
        ext_out_ready = 1'b1; tick(); ext_out_ready = 1'b0;
        chk("beef_popped", 32'(ext_out_valid), 32'd0);
        chk("beef_zero",   32'(ext_out_data),  32'd0);

        // Overflow on full, then full-with-pop accepts.
        proc_out_wr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            proc_output = 16'hA000 + 16'(i);
            tick();
        end
        proc_output = 16'hDEAD; tick();
        chk("ovf_set",  32'(out_overflow), 32'd1);
        chk("ovf_cnt",  32'(out_count),    32'd4);
        ext_out_ready = 1'b1; tick();
        chk("fullpop_cnt", 32'(out_count),    32'd4);
        chk("fullpop_ovf", 32'(out_overflow), 32'd1);
        idle();

        // Reset mid-transfer with two words in each FIFO.
        Reset = 1'b1; proc_output = '0; tick(); idle();
        ext_in_valid = 1'b1; proc_out_wr = 1'b1;
        ext_in_data = 16'h0101; proc_output = 16'h0A0A; tick();
        ext_in_data = 16'h0202; proc_output = 16'h0B0B; tick();
        chk("pre_rst_in",  32'(in_count),  32'd2);
        chk("pre_rst_out", 32'(out_count), 32'd2);
        Reset = 1'b1; ext_in_data = 16'h0303; proc_output = 16'h0000;
        proc_in_rd = 1'b1; ext_out_ready = 1'b1; tick();
        chk("rst_in_cnt",  32'(in_count),      32'd0);
        chk("rst_out_cnt", 32'(out_count),     32'd0);
        chk("rst_head",    32'(proc_input),    32'd0);
        chk("rst_ovf2",    32'(out_overflow),  32'd0);
        idle();
        tick();

`ifdef LIME_IO_CHANGE_DETECT_EN
        proc_output = 16'h0042; tick();
        chk("cd_change", 32'(out_count), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("cd_hold", 32'(out_count), 32'd1);
        proc_output = 16'h0043; proc_out_wr = 1'b1; tick(); proc_out_wr = 1'b0;
        chk("cd_both", 32'(out_count), 32'd2);
`endif

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            Reset         = ($urandom_range(0, 99) == 0);
            ext_in_valid  = $urandom_range(0, 1);
            ext_in_data   = 16'($urandom);
            proc_in_rd    = ($urandom_range(0, 2) == 0);
            proc_out_wr   = ($urandom_range(0, 2) != 0);
            ext_out_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) proc_output = 16'($urandom_range(0, 3));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
